// File: rtl/sc_regwrite_sequencer.sv
// Register-bank write-back sequencer: FIFO-buffered writes drained as one-hot active-low strobes, plus ordered bank clear.
// Latency: accept at edge N strobes from edge N+1; wrReady drops when full, while a clear is pending, or during CLEAR.
module sc_regwrite_sequencer #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int NUMREGS   = 2**ADDRWIDTH,
  localparam int PTRW      = $clog2(FIFO_DEPTH),
  localparam int CNTW      = PTRW + 1
) (
  input  logic                 SC_RegWRITE_CLOCK_50,
  input  logic                 SC_RegWRITE_RESET_InLow,
  input  logic                 SC_RegWRITE_wrValid_InHigh,
  input  logic [ADDRWIDTH-1:0] SC_RegWRITE_wrAddr_InBUS,
  input  logic [DATAWIDTH-1:0] SC_RegWRITE_wrData_InBUS,
  output logic                 SC_RegWRITE_wrReady_OutHigh,
  input  logic                 SC_RegWRITE_clearAll_InHigh,
  output logic [NUMREGS-1:0]   SC_RegWRITE_DecoC_OutBUS,
  output logic [NUMREGS-1:0]   SC_RegWRITE_clear_OutBUS,
  output logic [DATAWIDTH-1:0] SC_RegWRITE_data_OutBUS,
  output logic [CNTW-1:0]      SC_RegWRITE_count_OutBUS,
  output logic                 SC_RegWRITE_busy_OutHigh
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_t;

  logic [ADDRWIDTH+DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 pend_q, pend_d;
  state_t               state_q, state_d;
  logic [NUMREGS-1:0]   deco_q, deco_d, clear_q, clear_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 ready, push, pop, fifo_empty;
  logic [ADDRWIDTH-1:0] head_addr;
  logic [DATAWIDTH-1:0] head_data;
  logic [NUMREGS-1:0]   head_onehot;

  assign fifo_empty  = (count_q == '0);
  assign ready       = (count_q < CNTW'(FIFO_DEPTH)) && !pend_q && (state_q != ST_CLEAR);
  assign push        = SC_RegWRITE_wrValid_InHigh && ready;
  assign {head_addr, head_data} = mem_q[rd_ptr_q];
  assign head_onehot = {{(NUMREGS-1){1'b0}}, 1'b1} << head_addr;

  always_comb begin
    state_d = state_q;
    deco_d  = '1;
    clear_d = '1;
    data_d  = data_q;
    pop     = 1'b0;
    // A clearAll sampled on the edge leaving CLEAR must survive as a fresh request.
    pend_d  = SC_RegWRITE_clearAll_InHigh ? 1'b1 : pend_q;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          deco_d  = ~head_onehot;
          data_d  = head_data;
          state_d = ST_WRITE;
        end else if (pend_q) begin
          clear_d = '0;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        if (!SC_RegWRITE_clearAll_InHigh) pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PTRW'(push);
  assign rd_ptr_d = rd_ptr_q + PTRW'(pop);
  assign count_d  = count_q + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge SC_RegWRITE_CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= {SC_RegWRITE_wrAddr_InBUS, SC_RegWRITE_wrData_InBUS};
  end

  always_ff @(posedge SC_RegWRITE_CLOCK_50 or negedge SC_RegWRITE_RESET_InLow) begin
    if (!SC_RegWRITE_RESET_InLow) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      state_q  <= ST_IDLE;
      deco_q   <= '1;
      clear_q  <= '1;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      deco_q   <= deco_d;
      clear_q  <= clear_d;
      data_q   <= data_d;
    end
  end

  assign SC_RegWRITE_wrReady_OutHigh = ready;
  assign SC_RegWRITE_DecoC_OutBUS    = deco_q;
  assign SC_RegWRITE_clear_OutBUS    = clear_q;
  assign SC_RegWRITE_data_OutBUS     = data_q;
  assign SC_RegWRITE_count_OutBUS    = count_q;
  assign SC_RegWRITE_busy_OutHigh    = (count_q != '0) || pend_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sc_regwrite_sequencer.sv
// Bench for sc_regwrite_sequencer: directed steps plus random traffic, checked against a queue of expected bus events.
module tb_sc_regwrite_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 3;
  localparam logic [NR-1:0] ONES = '1;
  localparam logic [NR-1:0] ZEROS = '0;

  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dat = '0;
  logic rdy, busy;
  logic [NR-1:0] deco, clrbus;
  logic [DW-1:0] dout;
  logic [CW-1:0] cnt;

  typedef struct packed {logic is_clr; logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] mdl_bank [NR];
  logic [DW-1:0] dut_bank [NR];
  int strobe_addr[$];
  int strobe_cyc[$];
  int clear_cyc[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  sc_regwrite_sequencer dut (
    .SC_RegWRITE_CLOCK_50       (clk),
    .SC_RegWRITE_RESET_InLow    (rst_n),
    .SC_RegWRITE_wrValid_InHigh (vld),
    .SC_RegWRITE_wrAddr_InBUS   (addr),
    .SC_RegWRITE_wrData_InBUS   (dat),
    .SC_RegWRITE_wrReady_OutHigh(rdy),
    .SC_RegWRITE_clearAll_InHigh(clr),
    .SC_RegWRITE_DecoC_OutBUS   (deco),
    .SC_RegWRITE_clear_OutBUS   (clrbus),
    .SC_RegWRITE_data_OutBUS    (dout),
    .SC_RegWRITE_count_OutBUS   (cnt),
    .SC_RegWRITE_busy_OutHigh   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NR-1:0] onehot_n(input int a);
    logic [NR-1:0] v;
    v = ~(NR'(1) << a);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the request until an edge accepts it; rdy depends only on registered state.
  task automatic send(input int a, input logic [DW-1:0] d);
    logic acc;
    vld = 1'b1; addr = AW'(a); dat = d;
    for (int n = 0; n < 60; n++) begin
      acc = rdy;
      tick();
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Monitor: consume observed strobe/clear cycles, then record requests the next edge will accept.
  always @(negedge clk) begin
    int lows;
    exp_t e;
    logic [NR-1:0] exp_deco;
    if (rst_n) begin
      lows = $countones(~deco);
      chk("one_strobe_max", lows <= 1, 1);
      chk("strobe_clear_excl", (lows != 0) && (clrbus != ONES), 0);
      chk("clear_all_or_none", (clrbus == ONES) || (clrbus == ZEROS), 1);
      chk("count_bound", cnt <= 4, 1);
      if (lows != 0) begin
        for (int i = 0; i < NR; i++)
          if (!deco[i]) begin
            dut_bank[i] = dout;
            strobe_addr.push_back(i);
            strobe_cyc.push_back(cyc);
          end
        if (exp_q.size() == 0) chk("unexpected_strobe", deco, ONES);
        else begin
          e = exp_q.pop_front();
          exp_deco = onehot_n(int'(e.a));
          chk("strobe_kind", e.is_clr, 0);
          chk("strobe_bit", deco, exp_deco);
          chk("strobe_data", dout, e.d);
          mdl_bank[e.a] = e.d;
        end
      end
      if (clrbus == ZEROS) begin
        for (int i = 0; i < NR; i++) dut_bank[i] = '0;
        clear_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_clear", clrbus, ONES);
        else begin
          e = exp_q.pop_front();
          chk("clear_kind", e.is_clr, 1);
          for (int i = 0; i < NR; i++) mdl_bank[i] = '0;
        end
      end
      if (vld && rdy) exp_q.push_back('{1'b0, addr, dat});
      if (clr && !(exp_q.size() > 0 && exp_q[$].is_clr)) exp_q.push_back('{1'b1, AW'(0), DW'(0)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    for (int i = 0; i < NR; i++) begin mdl_bank[i] = '0; dut_bank[i] = '0; end

    // Reset values
    tick(); tick();
    chk("rst_deco", deco, ONES);
    chk("rst_clear", clrbus, ONES);
    chk("rst_data", dout, 0);
    chk("rst_count", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 1);
    rst_n = 1'b1;
    tick();

    // Single write latency
    vld = 1'b1; addr = 5'd3; dat = 32'hDEADBEEF;
    chk("t1_ready", rdy, 1);
    tick(); vld = 1'b0;
    chk("t1_count", cnt, 1);
    chk("t1_deco_pre", deco, ONES);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_strobe", deco, 32'hFFFFFFF7);
    chk("t1_data", dout, 32'hDEADBEEF);
    tick();
    chk("t1_release", deco, ONES);
    chk("t1_busy_fall", busy, 0);
    chk("t1_data_hold", dout, 32'hDEADBEEF);

    // Back-to-back drain with valid held
    strobe_addr.delete(); strobe_cyc.delete();
    for (int i = 0; i < 6; i++) send(i, $urandom);
    vld = 1'b0;
    wait_idle(50);
    chk("t2_nstrobes", strobe_addr.size(), 6);
    for (int i = 0; i < 6 && i < strobe_addr.size(); i++) chk("t2_order", strobe_addr[i], i);
    for (int i = 1; i < 6 && i < strobe_cyc.size(); i++) chk("t2_consecutive", strobe_cyc[i] - strobe_cyc[i-1], 1);

    // Same traffic with a clear pending after the first write
    strobe_addr.delete(); strobe_cyc.delete(); clear_cyc.delete();
    vld = 1'b1; addr = 5'd0; dat = $urandom; clr = 1'b1;
    tick(); clr = 1'b0;
    chk("t2b_ready_drop", rdy, 0);
    for (int i = 1; i < 6; i++) send(i, $urandom);
    vld = 1'b0;
    wait_idle(50);
    chk("t2b_nstrobes", strobe_addr.size(), 6);
    for (int i = 0; i < 6 && i < strobe_addr.size(); i++) chk("t2b_order", strobe_addr[i], i);
    chk("t2b_nclears", clear_cyc.size(), 1);
    if (clear_cyc.size() == 1 && strobe_cyc.size() == 6) begin
      chk("t2b_clear_after_w0", clear_cyc[0] > strobe_cyc[0], 1);
      chk("t2b_clear_before_w1", clear_cyc[0] < strobe_cyc[1], 1);
    end

    // Writes 7 and 9, clear on the edge of the second push
    send(7, 32'h0000_0707);
    addr = 5'd9; dat = 32'h0000_0909; clr = 1'b1;
    chk("t3_ready_pre", rdy, 1);
    tick(); vld = 1'b0; clr = 1'b0;
    chk("t3_strobe7", deco, onehot_n(7));
    chk("t3_ready_e0", rdy, 0);
    tick();
    chk("t3_strobe9", deco, onehot_n(9));
    chk("t3_data9", dout, 32'h0000_0909);
    chk("t3_ready_e1", rdy, 0);
    tick();
    chk("t3_clear", clrbus, ZEROS);
    chk("t3_deco_idle", deco, ONES);
    chk("t3_ready_e2", rdy, 0);
    tick();
    chk("t3_clear_end", clrbus, ONES);
    chk("t3_ready_back", rdy, 1);
    chk("t3_busy", busy, 0);

    // Clear on empty FIFO, re-requested during CLEAR
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk("t4_clear_wait", clrbus, ONES);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_clear1", clrbus, ZEROS);
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk("t4_gap", clrbus, ONES);
    chk("t4_gap_ready", rdy, 0);
    tick();
    chk("t4_clear2", clrbus, ZEROS);
    tick();
    chk("t4_end", clrbus, ONES);
    chk("t4_busy_end", busy, 0);
    chk("t4_ready_end", rdy, 1);

    // Reset while a strobe is low with work queued
    vld = 1'b1; addr = 5'd10; dat = 32'hA0A0_0010; tick();
    addr = 5'd11; dat = 32'hA0A0_0011; tick();
    addr = 5'd12; dat = 32'hA0A0_0012; tick();
    vld = 1'b0;
    chk("t5_pre_strobe", deco, onehot_n(11));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_deco", deco, ONES);
    chk("t5_clear", clrbus, ONES);
    chk("t5_count", cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data", dout, 0);
    exp_q.delete(); strobe_addr.delete();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_writes", strobe_addr.size(), 0);
    chk("t5_idle", busy, 0);

    // Random traffic; clears only issued from a fully idle sequencer
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!vld || acc) begin
        vld  = ($urandom_range(0, 9) < 7);
        addr = AW'($urandom_range(0, NR-1));
        dat  = $urandom;
      end
      clr = (!busy) && ($urandom_range(0, 19) == 0);
      acc = vld && rdy;
      tick();
    end
    vld = 1'b0; clr = 1'b0;
    wait_idle(100);
    chk("sb_empty", exp_q.size(), 0);
    for (int i = 0; i < NR; i++) chk("bank_match", dut_bank[i], mdl_bank[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
